solix_pipe_stage: RTL and testbench



---
 rtl/solix_pkg.sv | 21 ++
 rtl/solix_pipe_stage.sv | 89 ++++++++
 tb/tb_solix_pipe_stage.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/solix_pkg.sv
// rtl/solix_pkg.sv - shared word width and occupancy encoding for the Solix-16 pipe stage
package solix_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // {main_v, skid_v} = 2'b01 is unreachable; it folds into EMPTY here
    function automatic occ_e occ_of(input logic main_v, input logic skid_v);
        case ({main_v, skid_v})
            2'b10:   return OCC_ONE;
            2'b11:   return OCC_FULL;
            default: return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/solix_pipe_stage.sv
// rtl/solix_pipe_stage.sv - elastic one-cycle pipe stage with two-entry skid and registered in_ready
module solix_pipe_stage
    import solix_pkg::*;
#(
    parameter int WIDTH          = WORD_W,
    parameter bit FLUSH_CLR_DATA = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             main_v;
    logic             skid_v;
    logic             acc;
    logic             pop;
    occ_e             occ;

    assign out_valid = main_v;
    assign out_data  = main_data;
    assign in_ready  = !skid_v;
    assign count     = {1'b0, main_v} + {1'b0, skid_v};

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;
    assign occ = occ_of(main_v, skid_v);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            main_data <= '0;
            skid_data <= '0;
        end else if (flush) begin
            // flush wins over any handshake in the same cycle
            main_v <= 1'b0;
            skid_v <= 1'b0;
            if (FLUSH_CLR_DATA) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (acc) begin
                        main_v    <= 1'b1;
                        main_data <= in_data;
                    end
                end
                OCC_ONE: begin
                    if (acc && !pop) begin
                        skid_v    <= 1'b1;
                        skid_data <= in_data;
                    end else if (acc && pop) begin
                        main_data <= in_data;
                    end else if (pop) begin
                        main_v <= 1'b0;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        main_data <= skid_data;
                        skid_v    <= 1'b0;
                    end
                end
                default: begin
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(skid_v && !main_v));
        end
    end

endmodule

// File: tb/tb_solix_pipe_stage.sv
// tb/tb_solix_pipe_stage.sv - directed and random self-checking bench for solix_pipe_stage
module tb_solix_pipe_stage;
    import solix_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [1:0]        count;

    logic              in_ready_c;
    logic              out_valid_c;
    logic [WORD_W-1:0] out_data_c;
    logic [1:0]        count_c;

    int checks = 0;
    int errors = 0;

    logic [19:0] obs;
    logic [19:0] exp_v;
    assign obs = {out_valid, in_ready, count, out_data};

    solix_pipe_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    solix_pipe_stage #(.FLUSH_CLR_DATA(1'b1)) dut_clr (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .count(count_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        exp_v = {1'b0, 1'b1, 2'd0, 16'h0000};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_initial got %h exp %h", obs, exp_v);
        end
        in_valid = 1'b1; in_data = 16'h5A5A; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        exp_v = {1'b1, 1'b1, 2'd1, 16'h5A5A};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_preload got %h exp %h", obs, exp_v);
        end
        rst_n = 1'b0;
        #1;
        exp_v = {1'b0, 1'b1, 2'd0, 16'h0000};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_async got %h exp %h", obs, exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_streaming();
        logic [15:0] words [3];
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = words[i];
            @(negedge clk);
            exp_v = {1'b1, 1'b1, 2'd1, words[i]};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL stream_w%0d got %h exp %h", i, obs, exp_v);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs[19:16] !== {1'b0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL stream_drain got %h exp %h", obs[19:16], 4'b0100);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hAAAA;
        @(negedge clk);
        in_data = 16'hBBBB;
        @(negedge clk);
        exp_v = {1'b1, 1'b0, 2'd2, 16'hAAAA};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL bp_full got %h exp %h", obs, exp_v);
        end
        in_data = 16'hCCCC;
        @(negedge clk);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL bp_stall_stable got %h exp %h", obs, exp_v);
        end
        out_ready = 1'b1;
        @(negedge clk);
        exp_v = {1'b1, 1'b1, 2'd1, 16'hBBBB};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL bp_second got %h exp %h", obs, exp_v);
        end
        @(negedge clk);
        in_valid = 1'b0;
        exp_v = {1'b1, 1'b1, 2'd1, 16'hCCCC};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL bp_third got %h exp %h", obs, exp_v);
        end
        @(negedge clk);
        checks++;
        if (obs[19:16] !== {1'b0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL bp_drain got %h exp %h", obs[19:16], 4'b0100);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0001;
        @(negedge clk);
        in_data = 16'h0002; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        exp_v = {1'b1, 1'b1, 2'd1, 16'h0002};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL b2b_swap got %h exp %h", obs, exp_v);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h1234;
        @(negedge clk);
        in_data = 16'h5678;
        @(negedge clk);
        flush = 1'b1; in_data = 16'hDEAD; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        exp_v = {1'b0, 1'b1, 2'd0, 16'h1234};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL flush_keep got %h exp %h", obs, exp_v);
        end
        exp_v = {1'b0, 1'b1, 2'd0, 16'h0000};
        checks++;
        if ({out_valid_c, in_ready_c, count_c, out_data_c} !== exp_v) begin
            errors++;
            $display("FAIL flush_clr got %h exp %h", {out_valid_c, in_ready_c, count_c, out_data_c}, exp_v);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data === 16'hDEAD) begin
            errors++;
            $display("FAIL flush_after got %b/%h exp 0/not dead", out_valid, out_data);
        end
    endtask

    task automatic test_random();
        logic [15:0] q[$];
        logic        prev_stall;
        logic [15:0] prev_data;
        logic        acc_m;
        logic        pop_m;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            checks++;
            if (obs[19:16] !== {q.size() > 0, q.size() < 2, 2'(q.size())}) begin
                errors++;
                $display("FAIL rand_ctrl cyc %0d got %h exp %h", cyc, obs[19:16],
                         {q.size() > 0, q.size() < 2, 2'(q.size())});
            end
            if (q.size() > 0) begin
                checks++;
                if (out_data !== q[0]) begin
                    errors++;
                    $display("FAIL rand_data cyc %0d got %h exp %h", cyc, out_data, q[0]);
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_data !== prev_data) begin
                    errors++;
                    $display("FAIL rand_stable cyc %0d got %h exp %h", cyc, out_data, prev_data);
                end
            end
            checks++;
            if (!dut.main_v && dut.skid_v) begin
                errors++;
                $display("FAIL rand_illegal cyc %0d got 01 exp not 01", cyc);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            acc_m = in_valid && (q.size() < 2);
            pop_m = (q.size() > 0) && out_ready;
            prev_stall = (q.size() > 0) && !out_ready && !flush;
            prev_data  = out_data;
            if (flush) begin
                q.delete();
            end else begin
                if (pop_m) void'(q.pop_front());
                if (acc_m) q.push_back(in_data);
            end
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_back_to_back();
        test_flush();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
